// File: rtl/hazard_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_mc_if
// Description : Bundle of D/E/M/W pipeline signals consumed by the D-stage
//               hazard controller and the decisions it returns.
//               master : pipeline side (drives stage info, reads decisions)
//               slave  : hazard controller side
// Ports       : D_A, D_Tuse, {E,M,W}_A3/_Tnew/_RegWrite, E_md_start,
//               E_md_div, D_md_use, D_eret, {E,M}_CP0Write/_CP0Addr,
//               cnt_clr -> Stall, fwd_sel, eret_fwd, md_busy, stall_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_mc_if #(
    parameter int NSRC  = 2,
    parameter int AW    = 5,
    parameter int TW    = 2,
    parameter int CNT_W = 32
);
    logic [NSRC*AW-1:0] D_A;
    logic [NSRC*TW-1:0] D_Tuse;
    logic [AW-1:0]      E_A3, M_A3, W_A3;
    logic [TW-1:0]      E_Tnew, M_Tnew, W_Tnew;
    logic               E_RegWrite, M_RegWrite, W_RegWrite;
    logic               E_md_start, E_md_div, D_md_use, D_eret;
    logic               E_CP0Write, M_CP0Write;
    logic [4:0]         E_CP0Addr, M_CP0Addr;
    logic               cnt_clr;
    logic               Stall;
    logic [NSRC*2-1:0]  fwd_sel;
    logic               eret_fwd;
    logic               md_busy;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output D_A, D_Tuse, E_A3, M_A3, W_A3, E_Tnew, M_Tnew, W_Tnew,
               E_RegWrite, M_RegWrite, W_RegWrite, E_md_start, E_md_div,
               D_md_use, D_eret, E_CP0Write, M_CP0Write, E_CP0Addr,
               M_CP0Addr, cnt_clr,
        input  Stall, fwd_sel, eret_fwd, md_busy, stall_cnt
    );

    modport slave (
        input  D_A, D_Tuse, E_A3, M_A3, W_A3, E_Tnew, M_Tnew, W_Tnew,
               E_RegWrite, M_RegWrite, W_RegWrite, E_md_start, E_md_div,
               D_md_use, D_eret, E_CP0Write, M_CP0Write, E_CP0Addr,
               M_CP0Addr, cnt_clr,
        output Stall, fwd_sel, eret_fwd, md_busy, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_mc
// Description : D-stage hazard controller for a five-stage MIPS pipeline.
//               Tuse/Tnew stall and forward selection for NSRC operands,
//               internal HI/LO busy timer, EPC/eret hazard handling and a
//               saturating stall-cycle counter.
// Ports       : clk     - clock, rising edge
//               reset_n - asynchronous active-low reset
//               hz      - hazard_ctrl_mc_if.slave (stage info in,
//                         Stall/fwd_sel/eret_fwd/md_busy/stall_cnt out)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_mc #(
    parameter int NSRC     = 2,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 32
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    hazard_ctrl_mc_if.slave  hz
);

    localparam int              c_MD_MAX    = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int              c_MDW       = $clog2(c_MD_MAX + 1);
    localparam logic [c_MDW-1:0] c_MULT_LD  = c_MDW'(MULT_LAT);
    localparam logic [c_MDW-1:0] c_DIV_LD   = c_MDW'(DIV_LAT);
    localparam logic [TW-1:0]   c_TUSE_NONE = '1;
    localparam logic [4:0]      c_EPC_ADDR  = 5'd14;

    logic [c_MDW-1:0]  r_md_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [NSRC-1:0]   w_data_stall;
    logic [NSRC*2-1:0] w_fwd_sel;
    logic              w_md_busy;
    logic              w_md_stall;
    logic              w_eret_stall;
    logic              w_stall;

    // ------------------------------------------------------------------
    // Per-operand stall and forwarding decisions
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            logic [AW-1:0] w_a;
            logic [TW-1:0] w_tuse;
            logic          w_used;
            logic          w_nz;
            logic          w_stall_e, w_stall_m;
            logic          w_fwd_e, w_fwd_m, w_fwd_w;

            assign w_a    = hz.D_A[i*AW +: AW];
            assign w_tuse = hz.D_Tuse[i*TW +: TW];
            assign w_used = (w_tuse != c_TUSE_NONE);
            assign w_nz   = (w_a != '0);

            // Producer still Tnew cycles away but consumer needs it sooner.
            assign w_stall_e = w_used && w_nz && (w_a == hz.E_A3) && hz.E_RegWrite
                               && (hz.E_Tnew > w_tuse);
            assign w_stall_m = w_used && w_nz && (w_a == hz.M_A3) && hz.M_RegWrite
                               && (hz.M_Tnew > w_tuse);
            assign w_data_stall[i] = w_stall_e || w_stall_m;

            // Only a stage whose result is already computed (Tnew == 0) may forward.
            assign w_fwd_e = w_nz && (w_a == hz.E_A3) && hz.E_RegWrite && (hz.E_Tnew == '0);
            assign w_fwd_m = w_nz && (w_a == hz.M_A3) && hz.M_RegWrite && (hz.M_Tnew == '0);
            assign w_fwd_w = w_nz && (w_a == hz.W_A3) && hz.W_RegWrite && (hz.W_Tnew == '0);

            // Youngest producer wins.
            assign w_fwd_sel[i*2 +: 2] = w_fwd_e ? 2'd3 :
                                         w_fwd_m ? 2'd2 :
                                         w_fwd_w ? 2'd1 : 2'd0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // HI/LO busy timer; a start while busy is ignored, not a reload.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_md_cnt <= '0;
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - c_MDW'(1);
        end else if (hz.E_md_start) begin
            r_md_cnt <= hz.E_md_div ? c_DIV_LD : c_MULT_LD;
        end
    end

    assign w_md_busy  = (r_md_cnt != '0);
    // A start in E this cycle blocks D as well: the timer loads only at the edge.
    assign w_md_stall = hz.D_md_use && (w_md_busy || hz.E_md_start);

    // EPC still being written in E cannot be forwarded yet; from M it can.
    assign w_eret_stall = hz.D_eret && hz.E_CP0Write && (hz.E_CP0Addr == c_EPC_ADDR);
    assign hz.eret_fwd  = hz.D_eret && hz.M_CP0Write && (hz.M_CP0Addr == c_EPC_ADDR);

    assign w_stall = (|w_data_stall) || w_md_stall || w_eret_stall;

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter; clear beats increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (hz.cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign hz.Stall     = w_stall;
    assign hz.fwd_sel   = w_fwd_sel;
    assign hz.md_busy   = w_md_busy;
    assign hz.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_mc
// Description : Directed self-checking bench for hazard_ctrl_mc. Stall
//               counter built 4 bits wide so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_mc;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_bad;

    hazard_ctrl_mc_if #(.NSRC(2), .AW(5), .TW(2), .CNT_W(4)) hif ();

    hazard_ctrl_mc #(
        .NSRC(2), .AW(5), .TW(2), .MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hif.D_A        = '0;
        hif.D_Tuse     = '1;
        hif.E_A3       = '0; hif.M_A3   = '0; hif.W_A3   = '0;
        hif.E_Tnew     = '0; hif.M_Tnew = '0; hif.W_Tnew = '0;
        hif.E_RegWrite = 1'b0; hif.M_RegWrite = 1'b0; hif.W_RegWrite = 1'b0;
        hif.E_md_start = 1'b0; hif.E_md_div   = 1'b0;
        hif.D_md_use   = 1'b0; hif.D_eret     = 1'b0;
        hif.E_CP0Write = 1'b0; hif.M_CP0Write = 1'b0;
        hif.E_CP0Addr  = '0;   hif.M_CP0Addr  = '0;
        hif.cnt_clr    = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #2;
        chk("rst_md_busy",   32'(hif.md_busy),   0);
        chk("rst_stall_cnt", 32'(hif.stall_cnt), 0);
        chk("rst_stall",     32'(hif.Stall),     0);
        chk("rst_fwd_sel",   32'(hif.fwd_sel),   0);
        @(negedge clk);
        reset_n = 1'b1;

        // lw $8 in E, beq in D reading $8
        @(negedge clk);
        hif.E_A3 = 5'd8; hif.E_Tnew = 2'd2; hif.E_RegWrite = 1'b1;
        hif.D_A[4:0] = 5'd8; hif.D_Tuse[1:0] = 2'd0;
        #2 chk("lw_tuse0_stall", 32'(hif.Stall), 1);
        @(negedge clk);
        hif.D_Tuse[1:0] = 2'd1;
        #2 chk("lw_tuse1_stall", 32'(hif.Stall), 1);
        @(negedge clk);
        hif.E_Tnew = 2'd1;
        #2 chk("tnew1_tuse1_stall", 32'(hif.Stall), 0);
        chk("tnew1_no_e_fwd", 32'(hif.fwd_sel), 0);

        // M and W both write $9: M wins for operand 1
        @(negedge clk);
        idle();
        hif.M_A3 = 5'd9; hif.M_RegWrite = 1'b1;
        hif.W_A3 = 5'd9; hif.W_RegWrite = 1'b1;
        hif.D_A[9:5] = 5'd9; hif.D_Tuse[3:2] = 2'd1;
        #2 chk("fwd_m_op1", 32'(hif.fwd_sel), 32'h8);
        chk("fwd_m_nostall", 32'(hif.Stall), 0);
        // W only, operand 0
        @(negedge clk);
        hif.M_RegWrite = 1'b0;
        hif.D_A = {5'd0, 5'd9};
        #2 chk("fwd_w_op0", 32'(hif.fwd_sel), 32'h1);
        // E link write (Tnew 0) beats M and W, both operands
        @(negedge clk);
        hif.M_RegWrite = 1'b1;
        hif.E_A3 = 5'd9; hif.E_RegWrite = 1'b1; hif.E_Tnew = 2'd0;
        hif.D_A = {5'd9, 5'd9};
        #2 chk("fwd_e_both", 32'(hif.fwd_sel), 32'hF);
        // $0 never forwards
        @(negedge clk);
        idle();
        hif.M_A3 = 5'd0; hif.M_RegWrite = 1'b1;
        hif.D_Tuse = '0;
        #2 chk("zero_reg_fwd", 32'(hif.fwd_sel), 0);
        chk("zero_reg_stall", 32'(hif.Stall), 0);
        // M producer not ready yet (Tnew 1 > Tuse 0)
        @(negedge clk);
        hif.M_A3 = 5'd4; hif.M_Tnew = 2'd1;
        hif.D_A = {5'd0, 5'd4};
        #2 chk("m_stall", 32'(hif.Stall), 1);

        // div: busy for exactly 10 cycles
        @(negedge clk);
        idle();
        hif.E_md_start = 1'b1; hif.E_md_div = 1'b1;
        #2 chk("div_issue_busy", 32'(hif.md_busy), 0);
        @(negedge clk);
        hif.E_md_start = 1'b0; hif.E_md_div = 1'b0;
        hif.D_md_use = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #2;
            chk($sformatf("div_busy_%0d", k),  32'(hif.md_busy), 1);
            chk($sformatf("div_stall_%0d", k), 32'(hif.Stall),   1);
            @(negedge clk);
        end
        #2 chk("div_done_busy", 32'(hif.md_busy), 0);
        chk("div_done_stall", 32'(hif.Stall), 0);

        // mult with a second start on busy cycle 2: no reload, 5 cycles
        @(negedge clk);
        idle();
        hif.E_md_start = 1'b1;
        @(negedge clk);
        hif.E_md_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            hif.E_md_start = (k == 1);
            hif.E_md_div   = (k == 1);
            #2 chk($sformatf("mult_busy_%0d", k), 32'(hif.md_busy), 1);
            @(negedge clk);
        end
        hif.E_md_start = 1'b0; hif.E_md_div = 1'b0;
        #2 chk("mult_done_busy", 32'(hif.md_busy), 0);

        // eret vs mtc0 EPC
        @(negedge clk);
        idle();
        hif.D_eret = 1'b1; hif.E_CP0Write = 1'b1; hif.E_CP0Addr = 5'd14;
        #2 chk("eret_e_stall", 32'(hif.Stall), 1);
        chk("eret_e_fwd", 32'(hif.eret_fwd), 0);
        @(negedge clk);
        hif.E_CP0Write = 1'b0;
        hif.M_CP0Write = 1'b1; hif.M_CP0Addr = 5'd14;
        #2 chk("eret_m_stall", 32'(hif.Stall), 0);
        chk("eret_m_fwd", 32'(hif.eret_fwd), 1);
        @(negedge clk);
        hif.M_CP0Write = 1'b0;
        hif.E_CP0Write = 1'b1; hif.E_CP0Addr = 5'd13;
        #2 chk("eret_other_cp0", 32'(hif.Stall), 0);

        // stall counter: clear, 7 cycles, saturate, clear-over-increment
        @(negedge clk);
        idle();
        hif.cnt_clr = 1'b1;
        @(negedge clk);
        hif.cnt_clr = 1'b0;
        #2 chk("cnt_cleared", 32'(hif.stall_cnt), 0);
        hif.D_eret = 1'b1; hif.E_CP0Write = 1'b1; hif.E_CP0Addr = 5'd14;
        repeat (7) @(negedge clk);
        #2 chk("cnt_7", 32'(hif.stall_cnt), 7);
        repeat (10) @(negedge clk);
        #2 chk("cnt_sat", 32'(hif.stall_cnt), 15);
        hif.cnt_clr = 1'b1;
        @(negedge clk);
        idle();
        #2 chk("cnt_clr_prio", 32'(hif.stall_cnt), 0);

        // reset in the middle of a div
        @(negedge clk);
        hif.E_md_start = 1'b1; hif.E_md_div = 1'b1; hif.D_md_use = 1'b1;
        @(negedge clk);
        hif.E_md_start = 1'b0; hif.E_md_div = 1'b0;
        repeat (3) @(negedge clk);
        #2 chk("middiv_busy", 32'(hif.md_busy), 1);
        chk("middiv_cnt", 32'(hif.stall_cnt), 4);
        #1 reset_n = 1'b0;
        #1 chk("async_rst_busy", 32'(hif.md_busy), 0);
        chk("async_rst_cnt", 32'(hif.stall_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        hif.D_md_use = 1'b0;
        @(negedge clk);
        #2 chk("post_rst_busy", 32'(hif.md_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
